ifetch_ctrl: RTL

- Fetch-stage controller for the pipelined LC-3b core.
- Sequences instruction-memory reads, and drives the instruction register's load, flush and resp controls.
- Owns the fetch PC. Absorbs decode stalls with a one-entry skid buffer, and handles branch redirects, including redirects that arrive while a read is outstanding.

---
 rtl/ifetch_ctrl_pkg.sv | 6 +
 rtl/ifetch_ctrl_if.sv | 23 ++
 rtl/ifetch_skid_buf.sv | 48 ++++
 rtl/ifetch_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ifetch_ctrl_pkg.sv
// Shared LC-3b types for the fetch stage: word type, fetch FSM states, PC step.
package lc3b_types;
   typedef logic [15:0] lc3b_word;
   typedef enum logic [1:0] {FETCH, STALL, DRAIN} ifetch_state_t;
   localparam lc3b_word LC3B_PC_STEP = 16'd2;
endpackage

// File: rtl/ifetch_ctrl_if.sv
// Instruction-memory read bus between the fetch controller and imem.
interface ifetch_ctrl_if
   import lc3b_types::*;
   ;
   logic     imem_read;
   lc3b_word imem_address;
   logic     imem_resp;
   lc3b_word imem_rdata;

   modport master (
      output imem_read,
      output imem_address,
      input  imem_resp,
      input  imem_rdata
   );

   modport slave (
      input  imem_read,
      input  imem_address,
      output imem_resp,
      output imem_rdata
   );
endinterface

// File: rtl/ifetch_skid_buf.sv
// One-entry skid buffer holding a fetched word and its successor PC.
module ifetch_skid_buf
   import lc3b_types::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     capture,
   input  logic     rel,
   input  logic     clear,
   input  lc3b_word d_in,
   input  lc3b_word pc_in,
   output lc3b_word data,
   output lc3b_word pc,
   output logic     valid
);
   lc3b_word data_q, data_d;
   lc3b_word pc_q, pc_d;
   logic     valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (capture) begin
         data_d  = d_in;
         pc_d    = pc_in;
         valid_d = 1'b1;
      end else if (rel || clear) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   assign data  = data_q;
   assign pc    = pc_q;
   assign valid = valid_q;
endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch-stage controller: imem sequencing, IR load/flush, skid buffer, redirects.
// Define IFETCH_PERF_EN to add stall-cycle and flush saturating counters.
module ifetch_ctrl
   import lc3b_types::*;
#(
   parameter lc3b_word RESET_PC = 16'h0000,
   parameter lc3b_word PC_STEP  = LC3B_PC_STEP
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          stall,
   input  logic          redirect,
   input  lc3b_word      redirect_pc,
   ifetch_ctrl_if.master imem,
   output logic          ir_load,
   output logic          ir_flush,
   output lc3b_word      ir_in,
   output logic          ir_resp,
   output lc3b_word      pc_ir
`ifdef IFETCH_PERF_EN
   ,
   output logic [15:0]   perf_stall_cycles,
   output logic [15:0]   perf_flushes
`endif
);
   ifetch_state_t state_q, state_d;
   lc3b_word      pc_q, pc_d;
   lc3b_word      addr_q, addr_d;
   logic          ir_resp_q, ir_resp_d;
   lc3b_word      pc_ir_q, pc_ir_d;
   logic          ld, fl, cap, rel, clr;
   lc3b_word      buf_data, buf_pc;
   logic          buf_valid;
   lc3b_word      tgt, pc_next, addr_next;

   assign tgt       = {redirect_pc[15:1], 1'b0};
   assign pc_next   = pc_q + PC_STEP;
   assign addr_next = addr_q + PC_STEP;

   ifetch_skid_buf u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .capture (cap),
      .rel   (rel),
      .clear (clr),
      .d_in  (imem.imem_rdata),
      .pc_in (addr_next),
      .data  (buf_data),
      .pc    (buf_pc),
      .valid (buf_valid)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      ir_resp_d = ir_resp_q;
      pc_ir_d   = pc_ir_q;
      ld  = 1'b0;
      fl  = 1'b0;
      cap = 1'b0;
      rel = 1'b0;
      clr = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (redirect) begin
               fl        = 1'b1;
               pc_d      = tgt;
               ir_resp_d = 1'b0;
               if (imem.imem_resp) addr_d = tgt;
               else state_d = DRAIN;
            end else if (imem.imem_resp) begin
               pc_d   = pc_next;
               addr_d = pc_next;
               if (!stall) begin
                  ld        = 1'b1;
                  ir_resp_d = 1'b1;
                  pc_ir_d   = addr_next;
               end else begin
                  cap     = 1'b1;
                  state_d = STALL;
               end
            end
         end
         STALL: begin
            if (redirect) begin
               fl        = 1'b1;
               clr       = 1'b1;
               ir_resp_d = 1'b0;
               pc_d      = tgt;
               addr_d    = tgt;
               state_d   = FETCH;
            end else if (!stall) begin
               ld        = buf_valid;
               rel       = 1'b1;
               ir_resp_d = 1'b1;
               pc_ir_d   = buf_pc;
               state_d   = FETCH;
            end
         end
         DRAIN: begin
            // Old read still in flight: keep its address until it completes.
            if (redirect) begin
               fl   = 1'b1;
               pc_d = tgt;
            end else if (imem.imem_resp) begin
               addr_d  = pc_q;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         addr_q    <= RESET_PC;
         ir_resp_q <= 1'b0;
         pc_ir_q   <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         addr_q    <= addr_d;
         ir_resp_q <= ir_resp_d;
         pc_ir_q   <= pc_ir_d;
      end
   end

   assign imem.imem_read    = rst_n & (state_q != STALL);
   assign imem.imem_address = addr_q;
   assign ir_load  = rst_n & ld;
   assign ir_flush = rst_n & fl;
   assign ir_in    = (state_q == STALL) ? buf_data : imem.imem_rdata;
   assign ir_resp  = ir_resp_q;
   assign pc_ir    = pc_ir_q;

`ifdef IFETCH_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (state_q == STALL && stall_cnt_q != 16'hFFFF)
         stall_cnt_d = stall_cnt_q + 16'd1;
      if (fl && flush_cnt_q != 16'hFFFF)
         flush_cnt_d = flush_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_stall_cycles = stall_cnt_q;
   assign perf_flushes      = flush_cnt_q;
`endif
endmodule
